// File: rtl/aes_inv_cipher_iter.sv
// +--------------------------------------------------------------------------+
// | aes_inv_cipher_iter : iterative AES-128/192/256 decryptor, 1 round/clk  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

package aes_inv_cipher_iter_pkg;
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] t;
      t = {x, x} << n;
      return t[15:8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input int j);
      logic [7:0] r;
      r = 8'h01;
      for (int k = 1; k < j; k++) r = xtime(r);
      return r;
   endfunction
endpackage

module KeyExpansion #(
   parameter int NK = 4
) (
   input  logic [32*NK-1:0] i_key,
   output logic [127:0]     o_round_keys [NK+7]
);
   import aes_inv_cipher_iter_pkg::*;
   localparam int NR = NK + 6;
   localparam int NB = 4;
   localparam int NW = NB * (NR + 1);

   for (genvar i = 0; i < NW; i++) begin : g_word
      logic [31:0] word;
      if (i < NK) begin : g_load
         assign word = i_key[32*(NK-1-i) +: 32];
      end else if (i % NK == 0) begin : g_rot
         assign word = g_word[i-NK].word
                     ^ sub_word({g_word[i-1].word[23:0], g_word[i-1].word[31:24]})
                     ^ {rcon(i / NK), 24'h000000};
      end else if (NK > 6 && i % NK == 4) begin : g_sub
         assign word = g_word[i-NK].word ^ sub_word(g_word[i-1].word);
      end else begin : g_xor
         assign word = g_word[i-NK].word ^ g_word[i-1].word;
      end
   end

   for (genvar r = 0; r <= NR; r++) begin : g_rk
      assign o_round_keys[r] = {g_word[4*r].word, g_word[4*r+1].word,
                                g_word[4*r+2].word, g_word[4*r+3].word};
   end
endmodule

module invShiftRows (
   input  logic [127:0] i_state,
   output logic [127:0] o_state
);
   // row r of column c takes the byte from column c-r
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign o_state[127-8*(4*c+r) -: 8] = i_state[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
   end
endmodule

module inverse_subbyte (
   input  logic [127:0] i_state,
   output logic [127:0] o_state
);
   import aes_inv_cipher_iter_pkg::*;
   for (genvar b = 0; b < 16; b++) begin : g_byte
      assign o_state[8*b +: 8] = inv_sbox(i_state[8*b +: 8]);
   end
endmodule

module AddRoundKey (
   input  logic [127:0] i_state,
   input  logic [127:0] i_key,
   output logic [127:0] o_state
);
   assign o_state = i_state ^ i_key;
endmodule

module inverse_Mixcolumns (
   input  logic [127:0] i_state,
   output logic [127:0] o_state
);
   import aes_inv_cipher_iter_pkg::*;
   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign {a0, a1, a2, a3} = i_state[127-32*c -: 32];
      assign o_state[127-32*c -: 32] = {
         gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
         gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
         gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
         gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
   end
endmodule

module aes_inv_cipher_iter #(
   parameter int NK = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_valid,
   input  logic [32*NK-1:0]  key_in,
   output logic              key_ready,
   input  logic              in_valid,
   input  logic [127:0]      in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [127:0]      out_data,
   input  logic              out_ready,
   output logic              busy
);
   localparam int         NR       = NK + 6;
   localparam logic [3:0] NR_CNT   = 4'(NR);
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] ROUND    = 2'd1;
   localparam logic [1:0] DONE     = 2'd2;

   logic [1:0]       fsm_q, fsm_d;
   logic [3:0]       round_q, round_d;
   logic [127:0]     state_q, state_d;
   logic [32*NK-1:0] key_q, key_d;

   logic [127:0] round_keys [NR+1];
   logic [127:0] round_key, isr, isb, ark_in, ark, imc;
   logic [3:0]   rk_sel;

   KeyExpansion #(.NK(NK)) u_kexp (.i_key(key_q), .o_round_keys(round_keys));

   // in IDLE the single AddRoundKey instance performs the initial whitening
   assign rk_sel    = (fsm_q == IDLE) ? NR_CNT : round_q;
   assign round_key = round_keys[rk_sel];
   assign ark_in    = (fsm_q == IDLE) ? in_data : isb;

   invShiftRows       u_isr (.i_state(state_q), .o_state(isr));
   inverse_subbyte    u_isb (.i_state(isr), .o_state(isb));
   AddRoundKey        u_ark (.i_state(ark_in), .i_key(round_key), .o_state(ark));
   inverse_Mixcolumns u_imc (.i_state(ark), .o_state(imc));

   assign key_ready = (fsm_q == IDLE);
   assign in_ready  = key_ready && !key_valid;
   assign out_valid = (fsm_q == DONE);
   assign busy      = (fsm_q == ROUND) || (fsm_q == DONE);
   assign out_data  = state_q;

   always_comb begin
      fsm_d   = fsm_q;
      round_d = round_q;
      state_d = state_q;
      key_d   = key_q;
      case (fsm_q)
         IDLE: begin
            if (key_valid) begin
               key_d = key_in;
            end else if (in_valid) begin
               state_d = ark;
               round_d = NR_CNT - 4'd1;
               fsm_d   = ROUND;
            end
         end
         ROUND: begin
            if (round_q != 4'd0) begin
               state_d = imc;
               round_d = round_q - 4'd1;
            end else begin
               state_d = ark;
               fsm_d   = DONE;
            end
         end
         DONE: begin
            if (out_ready) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q   <= IDLE;
         round_q <= 4'd0;
         state_q <= '0;
         key_q   <= '0;
      end else begin
         fsm_q   <= fsm_d;
         round_q <= round_d;
         state_q <= state_d;
         key_q   <= key_d;
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_aes_inv_cipher_iter.sv
// +--------------------------------------------------------------------------+
// | tb_aes_inv_cipher_iter : scoreboard bench for AES-128/192/256 decryptors |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_aes_inv_cipher_iter;
   typedef struct {
      logic [127:0] data;
      int           lat;
   } exp_t;

   localparam logic [255:0] KEY128 = 256'h000102030405060708090a0b0c0d0e0f;
   localparam logic [255:0] KEY192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] KEYB   = 256'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CTB    = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PTB    = 128'h3243f6a8885a308d313198a2e0370734;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]   key_valid = '0;
   logic [2:0]   in_valid  = '0;
   logic [2:0]   out_ready = '1;
   logic [2:0]   key_ready, in_ready, out_valid, busy;
   logic [127:0] in_data  [3];
   logic [127:0] out_data [3];
   logic [127:0] key4 = '0;
   logic [191:0] key6 = '0;
   logic [255:0] key8 = '0;

   aes_inv_cipher_iter #(.NK(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid[0]), .key_in(key4), .key_ready(key_ready[0]),
      .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
      .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready[0]), .busy(busy[0]));
   aes_inv_cipher_iter #(.NK(6)) u_dut6 (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid[1]), .key_in(key6), .key_ready(key_ready[1]),
      .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
      .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready[1]), .busy(busy[1]));
   aes_inv_cipher_iter #(.NK(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid[2]), .key_in(key8), .key_ready(key_ready[2]),
      .in_valid(in_valid[2]), .in_data(in_data[2]), .in_ready(in_ready[2]),
      .out_valid(out_valid[2]), .out_data(out_data[2]), .out_ready(out_ready[2]), .busy(busy[2]));

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t exp_q [3][$];
   int   acc_q [3][$];
   logic [2:0] prev_ov = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: acceptance times, latency on rising out_valid, data on handshake.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_ov <= '0;
         for (int d = 0; d < 3; d++) acc_q[d].delete();
      end else begin
         for (int d = 0; d < 3; d++) begin
            if (in_valid[d] && in_ready[d]) acc_q[d].push_back(cyc + 1);
            if (out_valid[d] && !prev_ov[d]) begin
               checks++;
               if (exp_q[d].size() == 0 || acc_q[d].size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_out_valid dut=%0d got out_valid=1 required no pending block", d);
               end else if (cyc - acc_q[d][0] != exp_q[d][0].lat) begin
                  failures++;
                  $display("FAIL latency dut=%0d got=%0d required=%0d", d, cyc - acc_q[d][0], exp_q[d][0].lat);
               end
            end
            if (out_valid[d] && out_ready[d] && exp_q[d].size() != 0) begin
               e = exp_q[d].pop_front();
               checks++;
               if (out_data[d] !== e.data) begin
                  failures++;
                  $display("FAIL out_data dut=%0d got=%h required=%h", d, out_data[d], e.data);
               end
               if (acc_q[d].size() != 0) void'(acc_q[d].pop_front());
            end
         end
         prev_ov <= out_valid;
      end
   end

   task automatic check1(input string name, input logic got, input logic req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s got=%b required=%b", name, got, req);
      end
   endtask

   task automatic check128(input string name, input logic [127:0] got, input logic [127:0] req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_key(input int d, input logic [255:0] k);
      case (d)
         0:       key4 = k[127:0];
         1:       key6 = k[191:0];
         default: key8 = k;
      endcase
      key_valid[d] = 1'b1;
      @(negedge clk);
      check1("key_ready", key_ready[d], 1'b1);
      tick();
      key_valid[d] = 1'b0;
   endtask

   task automatic send(input int d, input logic [127:0] ct, input logic [127:0] pt, input int lat);
      bit ok;
      ok = 1'b0;
      exp_q[d].push_back('{pt, lat});
      in_data[d]  = ct;
      in_valid[d] = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready[d];
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout dut=%0d got in_ready=0 required 1", d);
      end
      tick();
      in_valid[d] = 1'b0;
   endtask

   task automatic drain(input int d);
      for (int i = 0; i < 100 && exp_q[d].size() != 0; i++) @(negedge clk);
      checks++;
      if (exp_q[d].size() != 0) begin
         failures++;
         $display("FAIL drain dut=%0d got pending=%0d required 0", d, exp_q[d].size());
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout required finish");
      $fatal(1);
   end

   initial begin
      bit seen;
      for (int d = 0; d < 3; d++) in_data[d] = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check1("rst_out_valid", out_valid[0], 1'b0);
      check1("rst_busy", busy[0], 1'b0);
      check128("rst_out_data", out_data[0], '0);
      check1("rst_key_ready", key_ready[0], 1'b1);
      check1("rst_in_ready", in_ready[0], 1'b1);
      tick();
      rst_n = 1'b1;

      load_key(0, KEY128); send(0, CT128, PT, 10); drain(0);
      load_key(1, KEY192); send(1, CT192, PT, 12); drain(1);
      load_key(2, KEY256); send(2, CT256, PT, 14); drain(2);

      // backpressure in DONE with an ignored block offered meanwhile
      out_ready[0] = 1'b0;
      send(0, CT128, PT, 10);
      for (int i = 0; i < 30 && !out_valid[0]; i++) @(negedge clk);
      in_data[0]  = CTB;
      in_valid[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check128("bp_data", out_data[0], PT);
         check1("bp_out_valid", out_valid[0], 1'b1);
         check1("bp_in_ready", in_ready[0], 1'b0);
      end
      tick();
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      check1("bp_release_idle", key_ready[0], 1'b1);
      check1("bp_release_valid", out_valid[0], 1'b0);

      // key load wins over a simultaneous block
      tick();
      key4         = KEYB[127:0];
      key_valid[0] = 1'b1;
      in_data[0]   = CTB;
      in_valid[0]  = 1'b1;
      exp_q[0].push_back('{PTB, 10});
      @(negedge clk);
      check1("prio_in_ready", in_ready[0], 1'b0);
      check1("prio_key_ready", key_ready[0], 1'b1);
      tick();
      key_valid[0] = 1'b0;
      @(negedge clk);
      check1("prio_accept_next", in_ready[0], 1'b1);
      tick();
      in_valid[0] = 1'b0;
      drain(0);

      // abort a block mid-flight with reset
      send(0, CTB, PTB, 10);
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      exp_q[0].delete();
      #1;
      check1("abort_out_valid", out_valid[0], 1'b0);
      check1("abort_busy", busy[0], 1'b0);
      check128("abort_out_data", out_data[0], '0);
      check1("abort_key_ready", key_ready[0], 1'b1);
      check1("abort_in_ready", in_ready[0], 1'b1);
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid[0]) seen = 1'b1;
      end
      check1("abort_no_output", seen, 1'b0);
      load_key(0, KEY128); send(0, CT128, PT, 10); drain(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/aes_inv_cipher_iter.md
AES_INV_CIPHER_ITER -- requirements
Module: aes_inv_cipher_iter

Interface
REQ-001 SHALL have parameter NK, default 4, meaning key length in 32-bit words; legal values 4, 6, 8 (AES-128/192/256).
REQ-002 SHALL derive local constant NR = NK+6 (10/12/14 rounds) and NB = 4; NR SHALL NOT be user-settable.
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port key_valid, input, 1, request to load a new cipher key.
REQ-006 SHALL have port key_in, input, 32*NK, cipher key, FIPS-197 byte order, MSB = first byte.
REQ-007 SHALL have port key_ready, output, 1, key load accepted this cycle when key_valid is high.
REQ-008 SHALL have port in_valid, input, 1, ciphertext block present.
REQ-009 SHALL have port in_data, input, 128, ciphertext block, MSB = byte 0.
REQ-010 SHALL have port in_ready, output, 1, block accepted this cycle when in_valid is high.
REQ-011 SHALL have port out_valid, output, 1, plaintext block available.
REQ-012 SHALL have port out_data, output, 128, plaintext block, MSB = byte 0.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts out_data this cycle.
REQ-014 SHALL have port busy, output, 1, high in ROUND and DONE states.

Function
REQ-015 SHALL hold the key in a 32*NK-bit register and generate all NB*(NR+1) schedule words from it with the team's existing KeyExpansion block; round key r = words 4r..4r+3.
REQ-016 SHALL implement FSM states IDLE, ROUND, DONE; one round per clock using one instance each of invShiftRows, inverse_subbyte, AddRoundKey, inverse_Mixcolumns.
REQ-017 key_ready SHALL be high only in IDLE; key_valid && key_ready SHALL load key_in into the key register on that edge; the state stays IDLE.
REQ-018 in_ready SHALL equal (state==IDLE) && !key_valid; key load has priority over block acceptance in the same cycle.
REQ-019 On in_valid && in_ready: state_reg <= in_data ^ roundkey[NR], round counter <= NR-1, FSM -> ROUND.
REQ-020 In ROUND with counter r >= 1: state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ roundkey[r]), r <= r-1.
REQ-021 In ROUND with r == 0: state_reg <= InvSubBytes(InvShiftRows(state_reg)) ^ roundkey[0], FSM -> DONE.
REQ-022 Latency SHALL be exactly NR clocks from the accepting edge to the edge that raises out_valid (10/12/14).
REQ-023 out_valid SHALL be high in DONE only; out_data SHALL equal state_reg and stay stable while out_valid && !out_ready.
REQ-024 out_valid && out_ready SHALL return the FSM to IDLE on that edge; the next block SHALL NOT be accepted before the following cycle (max throughput one block per NR+2 clocks).
REQ-025 Round counter width SHALL be 4 bits; it SHALL never wrap below 0 (decrement only while r >= 1).
REQ-026 in_valid during ROUND/DONE and key_valid outside IDLE SHALL be ignored with no state change; the inputs are not captured.
REQ-027 out_data SHALL be driven from a register; no combinational path from in_data to out_data.

Reset
REQ-028 rst_n low SHALL immediately force FSM = IDLE, counter = 0, state_reg = 0, key register = 0; outputs out_valid = 0, busy = 0, out_data = 0, key_ready = 1, in_ready = !key_valid.
REQ-029 Reset asserted mid-operation SHALL abort the block; no out_valid SHALL appear for it after reset release.
REQ-030 After rst_n deasserts, the first operation SHALL be accepted on the first rising edge at which it is presented.

Verification
REQ-031 NK=4: load key 000102030405060708090a0b0c0d0e0f, send 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_valid exactly 10 clocks after acceptance.
REQ-032 NK=6: key 000102...1617, block dda97ca4864cdfe06eaf70a0ec0d7191 -> 00112233445566778899aabbccddeeff after 12 clocks.
REQ-033 NK=8: key 000102...1e1f, block 8ea2b7ca516745bfeafc49904b496089 -> 00112233445566778899aabbccddeeff after 14 clocks.
REQ-034 Backpressure: hold out_ready low 5 cycles in DONE -> out_valid and out_data stable, in_ready low, new in_valid ignored; release -> IDLE next cycle.
REQ-035 Key_valid and in_valid both high in IDLE -> key loaded, block not accepted; next cycle block accepted and decrypted under the new key.
REQ-036 Pulse rst_n low at round 5 -> outputs at reset values immediately, no out_valid afterwards; a following block decrypts correctly.
